mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
- Parametrised successor to the fixed 2/3-input combinational selectors in the datapath: NUM_IN-way, WIDTH-bit select with a registered output stage and valid/ready handshake.
- Includes a 2-entry skid buffer so in_ready is a register output, with no combinational ready path back to the producer.
- Used between pipeline stages, e.g. writeback source select (regs/mem/pc) and register-destination select (rt/rd/ra), where the result must be timing-isolated.
- Adds out-of-range select detection with a sticky error flag.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select for the current beat.
- in_valid  input  1  producer presents a beat.
- in_ready  output  1  block can accept a beat; registered.
- out_data  output  WIDTH  selected data; registered.
- out_sel  output  SEL_W  in_sel value that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  consumer accepts the beat.
- sel_err  output  1  sticky: an out-of-range select was accepted.
- err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Reset (async assert, sync deassert is the integrator's concern); all registers clear:
  - out_valid=0, out_data=0, out_sel=0.
  - skid entry empty.
  - in_ready=1.
  - sel_err=0.
- Accept: a beat is accepted when in_valid && in_ready at the clk edge.
- Emit: a beat leaves when out_valid && out_ready.
- Selection:
  - in_sel < NUM_IN: chosen = input in_sel.
  - in_sel >= NUM_IN: chosen = input NUM_IN-1 (default-to-last, matching the existing selectors) and the beat is flagged out-of-range.
  - Selection is computed combinationally on the input side and only the chosen WIDTH bits are stored.
- Storage: two entries, main (drives outputs) and skid.
- Latency: an accepted beat appears on out_data the next cycle when main is empty or draining. Throughput is 1 beat/cycle while out_ready=1.
- Register updates per edge:
  - Main empty, or main emitting with skid empty: an accepted beat loads main.
  - Main emitting with skid full: skid moves to main. in_ready was 0, so no accept is possible.
  - Main full and not emitting: an accepted beat loads skid.
  - out_valid = main occupied.
  - in_ready next = skid empty after this edge.
- Order: beats leave in acceptance order. No beat is dropped or duplicated.
- Stall: out_data/out_sel hold stable while out_valid=1 and out_ready=0.
- sel_err:
  - Sets on the edge where an out-of-range beat is accepted.
  - A select presented but not accepted does not set it.
  - err_clr=1 clears it. If set and clear occur in the same edge, set wins.
- Full-buffer behaviour: with both entries full, in_valid is ignored and in_data/in_sel may change freely without effect.
- Reset mid-operation: both entries are discarded immediately. out_valid falls asynchronously with rst.
- No X propagation: out_data is 0 whenever out_valid has never been set since reset.

Test Plan:
- Reset then stream: WIDTH=32, NUM_IN=3, inputs {0x11111111, 0x22222222, 0x33333333}, sel 0,1,2 on consecutive cycles, out_ready=1 -> out_data 0x11111111, 0x22222222, 0x33333333 on cycles 1,2,3; out_valid high 3 cycles; in_ready stays 1.
- Backpressure: out_ready=0, send sel=1 then sel=2 -> out_data holds 0x22222222; in_ready=0 after the 2nd accept. Raise out_ready -> 0x22222222 then 0x33333333 emitted; in_ready back to 1 a cycle later. No loss.
- Out-of-range select: NUM_IN=3, in_sel=3 accepted -> out_data=0x33333333, out_sel=3, sel_err=1. Pulse err_clr -> sel_err=0. err_clr concurrent with another sel=3 accept -> sel_err stays 1.
- Blocked select: in_sel=3 with in_valid=1 while in_ready=0 -> sel_err remains 0.
- Async reset mid-stream: assert rst between clk edges with both entries full -> out_valid=0, in_ready=1, sel_err=0 immediately. The first beat after release emits with 1-cycle latency.
- Param sweep: NUM_IN=5, SEL_W=3, WIDTH=8, inputs k*0x10 for k=0..4; random valid/ready, 1000 beats -> scoreboard match; sel 5..7 map to 0x40 with sel_err set.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN-way, WIDTH-bit selector with a registered output stage and
// a valid/ready handshake. A 2-entry buffer (main + skid) keeps in_ready a pure
// register output, so there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel     select for the current beat
//   in_valid   producer presents a beat
//   in_ready   block can accept a beat (registered)
//   out_data   selected data (registered)
//   out_sel    in_sel value that produced out_data
//   out_valid  out_data/out_sel valid
//   out_ready  consumer accepts the beat
//   sel_err    sticky: an out-of-range select was accepted
//   err_clr    synchronous clear of sel_err (a same-edge set wins)
//
// Parameter constraints: 2 <= NUM_IN <= 16 and 2**SEL_W >= NUM_IN.
module mux_n_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic [WIDTH-1:0] chosen;
  logic             sel_hit;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;

  logic accept;
  logic emit;

  // Input-side selection; out-of-range selects fall back to the last input.
  always_comb begin
    chosen  = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    sel_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        chosen  = in_data[k*WIDTH +: WIDTH];
        sel_hit = 1'b1;
      end
    end
  end

  assign accept = in_valid & in_ready_q;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || (emit && !skid_valid_q)) begin
      // Main is free this edge: load it directly, or let it go empty.
      if (accept) begin
        main_data_d  = chosen;
        main_sel_d   = in_sel;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (emit) begin
      // Skid is full here, so in_ready was low and nothing is accepted.
      main_data_d  = skid_data_q;
      main_sel_d   = skid_sel_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      // Main stalled: park the beat in skid.
      skid_data_d  = chosen;
      skid_sel_d   = in_sel;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;

    sel_err_d = sel_err_q;
    if (accept && !sel_hit) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      sel_err_q    <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_valid = main_valid_q;
  assign sel_err   = sel_err_q;

endmodule
